// File: rtl/sdrc_wb_traffic_gen.sv
// sdrc_wb_traffic_gen
// Wishbone master that exercises the SDRAM controller WB slave port with
// incrementing bursts of a seed+index pattern, then reads the region back
// and counts mismatches. Optional ack watchdog: SDRC_WB_TG_TIMEOUT_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for start
// WAIT_INIT | run accepted, holding off until sdr_init_done
// WR_BURST  | write burst on the bus
// WR_GAP    | one-cycle bus release after a write burst
// RD_BURST  | read burst on the bus, returned data checked on ack
// RD_GAP    | one-cycle bus release after a read burst
// FINISH    | run complete; done set, busy cleared

module sdrc_wb_traffic_gen #(
    parameter int WB_DW      = 32,
    parameter int WB_AW      = 26,
    parameter int BURST_LEN  = 8,
    parameter int NUM_BURSTS = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic               wb_clk_i,
    input  logic               wb_resetn,
    input  logic               sdr_init_done,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WB_AW-1:0]   base_addr,
    input  logic [WB_DW-1:0]   seed,
    output logic               busy,
    output logic               done,
    output logic [15:0]        err_cnt,
    output logic [WB_AW-1:0]   first_err_addr,
    output logic               timeout,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [WB_AW-1:0]   wb_addr_o,
    output logic [WB_DW-1:0]   wb_dat_o,
    output logic [WB_DW/8-1:0] wb_sel_o,
    output logic [2:0]         wb_cti_o,
    input  logic [WB_DW-1:0]   wb_dat_i,
    input  logic               wb_ack_i
);

    localparam int                SEL_W      = WB_DW / 8;
    localparam int                BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WB_AW-1:0]  ADDR_STEP  = WB_AW'(SEL_W);
    localparam logic [BEAT_W-1:0] BEAT_LOAD  = BEAT_W'(BURST_LEN - 1);
    localparam logic [15:0]       BURST_LOAD = 16'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_INIT = 3'd1,
        WR_BURST  = 3'd2,
        WR_GAP    = 3'd3,
        RD_BURST  = 3'd4,
        RD_GAP    = 3'd5,
        FINISH    = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         mode_q;
    logic [WB_AW-1:0]   base_q;
    logic [WB_AW-1:0]   addr_q;
    logic [WB_DW-1:0]   seed_q;
    logic [WB_DW-1:0]   pat_q;
    logic [BEAT_W-1:0]  beats_left;
    logic [15:0]        bursts_left;
    logic               phase_end_q;
    logic               in_burst;
    logic               beat_ack;
    logic               last_beat;
    logic               wd_expire;

    assign in_burst  = (state == WR_BURST) || (state == RD_BURST);
    assign beat_ack  = in_burst && wb_ack_i;
    assign last_beat = (beats_left == '0);
    assign wb_addr_o = addr_q;
    assign wb_dat_o  = pat_q;

`ifdef SDRC_WB_TG_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT);

    logic [TO_W-1:0] wd_left;

    // Ack watchdog: down-counts stalled strobe cycles, reloads on ack or off-bus.
    assign wd_expire = in_burst && !wb_ack_i && (wd_left == TO_W'(1));

    // Watchdog counter and sticky timeout flag (cleared by an accepted start).
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            wd_left <= TO_LOAD;
            timeout <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                timeout <= 1'b0;
            end else if (wd_expire) begin
                timeout <= 1'b1;
            end
            if (in_burst && !wb_ack_i && !wd_expire) begin
                wd_left <= wd_left - TO_W'(1);
            end else begin
                wd_left <= TO_LOAD;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign wd_expire          = 1'b0;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and WB control outputs.
    always_comb begin
        state_nxt = state;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_sel_o  = '0;
        wb_cti_o  = 3'b000;
        case (state)
            IDLE: begin
                if (start) state_nxt = WAIT_INIT;
            end
            WAIT_INIT: begin
                if (sdr_init_done) state_nxt = (mode_q == 2'd2) ? RD_BURST : WR_BURST;
            end
            WR_BURST, RD_BURST: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = (state == WR_BURST);
                wb_sel_o = '1;
                wb_cti_o = last_beat ? 3'b111 : 3'b010;
                if (beat_ack && last_beat) state_nxt = (state == WR_BURST) ? WR_GAP : RD_GAP;
                if (wd_expire) state_nxt = IDLE;
            end
            WR_GAP: begin
                if (!phase_end_q)        state_nxt = WR_BURST;
                else if (mode_q == 2'd1) state_nxt = FINISH;
                else                     state_nxt = RD_BURST;
            end
            RD_GAP: begin
                state_nxt = phase_end_q ? FINISH : RD_BURST;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Run setup, address/pattern stepping, burst counters, checker and status.
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            mode_q         <= 2'd0;
            base_q         <= '0;
            addr_q         <= '0;
            seed_q         <= '0;
            pat_q          <= '0;
            beats_left     <= '0;
            bursts_left    <= '0;
            phase_end_q    <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                // reserved mode 3 behaves as write-then-check
                mode_q         <= (mode == 2'd3) ? 2'd0 : mode;
                base_q         <= base_addr;
                addr_q         <= base_addr;
                seed_q         <= seed;
                pat_q          <= seed;
                beats_left     <= BEAT_LOAD;
                bursts_left    <= BURST_LOAD;
                phase_end_q    <= 1'b0;
                err_cnt        <= '0;
                first_err_addr <= '0;
                busy           <= 1'b1;
                done           <= 1'b0;
            end
            if (beat_ack) begin
                addr_q <= addr_q + ADDR_STEP;
                pat_q  <= pat_q + WB_DW'(1);
                if (state == RD_BURST && wb_dat_i != pat_q) begin
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    if (err_cnt == 16'd0)    first_err_addr <= addr_q;
                end
                if (last_beat) begin
                    beats_left  <= BEAT_LOAD;
                    phase_end_q <= (bursts_left == 16'd0);
                    if (bursts_left == 16'd0) begin
                        bursts_left <= BURST_LOAD;
                        // read-back phase restarts at g = 0
                        if (state == WR_BURST) begin
                            addr_q <= base_q;
                            pat_q  <= seed_q;
                        end
                    end else begin
                        bursts_left <= bursts_left - 16'd1;
                    end
                end else begin
                    beats_left <= beats_left - BEAT_W'(1);
                end
            end
            if (state_nxt == FINISH || wd_expire) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdrc_wb_traffic_gen.sv
// Directed bench for sdrc_wb_traffic_gen: 32-bit WB, 4 bursts of 8 beats,
// behavioural WB slave memory with wait states, read corruption and no-ack.
module tb_sdrc_wb_traffic_gen;

    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic        start;
    logic [1:0]  mode;
    logic [25:0] base_addr;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic [15:0] err_cnt;
    logic [25:0] first_err_addr;
    logic        timeout;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [25:0] wb_addr;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [31:0] wb_dat_i;
    logic        wb_ack;

    sdrc_wb_traffic_gen #(
        .WB_DW(32), .WB_AW(26), .BURST_LEN(8), .NUM_BURSTS(4), .TIMEOUT(16)
    ) dut (
        .wb_clk_i       (clk),
        .wb_resetn      (rst_n),
        .sdr_init_done  (init_done),
        .start          (start),
        .mode           (mode),
        .base_addr      (base_addr),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .timeout        (timeout),
        .wb_cyc_o       (wb_cyc),
        .wb_stb_o       (wb_stb),
        .wb_we_o        (wb_we),
        .wb_addr_o      (wb_addr),
        .wb_dat_o       (wb_dat_o),
        .wb_sel_o       (wb_sel),
        .wb_cti_o       (wb_cti),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // slave controls
    int          ws;
    logic        noack;
    logic        corrupt_en;
    logic [25:0] corrupt_addr;
    logic [31:0] mem [0:1023];
    int          wcnt;

    // behavioural WB slave memory
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wcnt     <= 0;
            wb_dat_i <= 32'h0;
        end else begin
            wb_ack <= 1'b0;
            if (wb_cyc && wb_stb && !wb_ack && !noack) begin
                if (wcnt == ws) begin
                    wb_ack <= 1'b1;
                    wcnt   <= 0;
                    if (wb_we) mem[wb_addr[11:2]] <= wb_dat_o;
                    else wb_dat_i <= mem[wb_addr[11:2]] ^
                                     ((corrupt_en && wb_addr == corrupt_addr) ? 32'h1 : 32'h0);
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // bus monitor
    logic        mon_clr;
    logic [31:0] exp_base;
    logic [31:0] exp_seed;
    logic [31:0] wr_n, rd_n, addr_bad, dat_bad, cti_bad, sel_bad, stab_bad;
    logic [31:0] gaps, gap_bad, low_run, stb_cnt;
    logic        seen_cyc;
    logic        prev_stb, prev_ack, prev_we;
    logic [25:0] prev_addr;
    logic [31:0] prev_dat;

    // beat-by-beat address/data/cti/stability and inter-burst gap accounting
    always @(negedge clk) begin
        if (mon_clr) begin
            wr_n <= 0; rd_n <= 0; addr_bad <= 0; dat_bad <= 0; cti_bad <= 0;
            sel_bad <= 0; stab_bad <= 0; gaps <= 0; gap_bad <= 0; low_run <= 0;
            stb_cnt <= 0; seen_cyc <= 1'b0; prev_stb <= 1'b0; prev_ack <= 1'b0;
            prev_we <= 1'b0; prev_addr <= '0; prev_dat <= '0;
        end else begin
            if (wb_stb) stb_cnt <= stb_cnt + 1;
            if (wb_stb && wb_sel != 4'hF) sel_bad <= sel_bad + 1;
            if (wb_cyc && wb_stb && wb_ack) begin
                if (wb_we) begin
                    if ({6'b0, wb_addr} != exp_base + (wr_n << 2)) addr_bad <= addr_bad + 1;
                    if (wb_dat_o != exp_seed + wr_n) dat_bad <= dat_bad + 1;
                    if (wb_cti != ((wr_n[2:0] == 3'd7) ? 3'b111 : 3'b010)) cti_bad <= cti_bad + 1;
                    wr_n <= wr_n + 1;
                end else begin
                    if ({6'b0, wb_addr} != exp_base + (rd_n << 2)) addr_bad <= addr_bad + 1;
                    if (wb_cti != ((rd_n[2:0] == 3'd7) ? 3'b111 : 3'b010)) cti_bad <= cti_bad + 1;
                    rd_n <= rd_n + 1;
                end
            end
            if (wb_stb && prev_stb && !prev_ack &&
                (wb_addr != prev_addr || wb_dat_o != prev_dat || wb_we != prev_we))
                stab_bad <= stab_bad + 1;
            prev_stb  <= wb_stb;
            prev_ack  <= wb_ack;
            prev_we   <= wb_we;
            prev_addr <= wb_addr;
            prev_dat  <= wb_dat_o;
            if (busy) begin
                if (!wb_cyc) begin
                    low_run <= low_run + 1;
                end else begin
                    if (seen_cyc && low_run != 0) begin
                        gaps <= gaps + 1;
                        if (low_run != 1) gap_bad <= gap_bad + 1;
                    end
                    low_run  <= 0;
                    seen_cyc <= 1'b1;
                end
            end
        end
    end

    int n_vec;
    int n_miss;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] m, input logic [31:0] b, input logic [31:0] s);
        exp_base = b;
        exp_seed = s;
        mon_clr  = 1'b1;
        tick(1);
        mon_clr   = 1'b0;
        mode      = m;
        base_addr = b[25:0];
        seed      = s;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int n;
        n_vec = 0; n_miss = 0;
        ws = 0; noack = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0;
        init_done = 1'b1; start = 1'b0; mode = 2'd0; base_addr = '0; seed = '0;
        exp_base = 0; exp_seed = 0; mon_clr = 1'b1;
        rst_n = 1'b0;
        tick(3);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_cyc",  {31'b0, wb_cyc}, 32'd0);
        check("rst_stb",  {31'b0, wb_stb}, 32'd0);
        check("rst_err",  {16'b0, err_cnt}, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // mode 0, ideal memory
        run(2'd0, 32'h100, 32'hA5A50000);
        wait_done("m0_done", 2000);
        check("m0_busy", {31'b0, busy}, 32'd0);
        check("m0_err", {16'b0, err_cnt}, 32'd0);
        check("m0_wr_n", wr_n, 32'd32);
        check("m0_rd_n", rd_n, 32'd32);
        check("m0_addr_bad", addr_bad, 32'd0);
        check("m0_dat_bad", dat_bad, 32'd0);
        check("m0_cti_bad", cti_bad, 32'd0);
        check("m0_sel_bad", sel_bad, 32'd0);
        check("m0_gaps", gaps, 32'd7);
        check("m0_gap_bad", gap_bad, 32'd0);
        check("m0_mem_first", mem[10'h040], 32'hA5A50000);
        check("m0_mem_last", mem[10'h05F], 32'hA5A5001F);
        tick(3);
        check("m0_done_held", {31'b0, done}, 32'd1);

        // mode 2 with corrupted word at 0x108
        corrupt_en = 1'b1; corrupt_addr = 26'h108;
        run(2'd2, 32'h100, 32'hA5A50000);
        wait_done("m2_done", 2000);
        check("m2_err", {16'b0, err_cnt}, 32'd1);
        check("m2_first_err", {6'b0, first_err_addr}, 32'h108);
        check("m2_wr_n", wr_n, 32'd0);
        check("m2_rd_n", rd_n, 32'd32);
        check("m2_addr_bad", addr_bad, 32'd0);
        corrupt_en = 1'b0;

        // start before init_done, second start while busy ignored
        init_done = 1'b0;
        run(2'd1, 32'h200, 32'h12340000);
        tick(10);
        mode = 2'd2; base_addr = 26'h0; seed = 32'h0; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(38);
        check("init_no_stb", stb_cnt, 32'd0);
        check("init_busy", {31'b0, busy}, 32'd1);
        init_done = 1'b1;
        check("init_stb_before", {31'b0, wb_stb}, 32'd0);
        tick(1);
        check("init_stb_after", {31'b0, wb_stb}, 32'd1);
        check("init_addr", {6'b0, wb_addr}, 32'h200);
        check("init_we", {31'b0, wb_we}, 32'd1);
        check("init_cti", {29'b0, wb_cti}, 32'd2);
        wait_done("init_done", 2000);
        check("init_wr_n", wr_n, 32'd32);
        check("init_rd_n", rd_n, 32'd0);
        check("init_dat_bad", dat_bad, 32'd0);
        check("init_gaps", gaps, 32'd3);

        // three wait states per beat, reserved mode 3 acts as mode 0
        ws = 3;
        run(2'd3, 32'h300, 32'h55AA0000);
        wait_done("ws_done", 4000);
        check("ws_err", {16'b0, err_cnt}, 32'd0);
        check("ws_wr_n", wr_n, 32'd32);
        check("ws_rd_n", rd_n, 32'd32);
        check("ws_stab_bad", stab_bad, 32'd0);
        check("ws_addr_bad", addr_bad, 32'd0);
        check("ws_gaps", gaps, 32'd7);
        check("ws_gap_bad", gap_bad, 32'd0);
        ws = 0;

        // reset in the middle of a write burst
        run(2'd1, 32'h400, 32'h0F0F0000);
        n = 0;
        while (wr_n < 3 && n < 200) begin tick(1); n++; end
        check("rr_reached_beat", {31'b0, (wr_n >= 3)}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rr_cyc", {31'b0, wb_cyc}, 32'd0);
        check("rr_stb", {31'b0, wb_stb}, 32'd0);
        check("rr_busy", {31'b0, busy}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        run(2'd0, 32'h400, 32'h0F0F0000);
        wait_done("rr_done", 2000);
        check("rr_err", {16'b0, err_cnt}, 32'd0);
        check("rr_wr_n", wr_n, 32'd32);
        check("rr_rd_n", rd_n, 32'd32);

        // slave never acks
        noack = 1'b1;
        run(2'd1, 32'h500, 32'h0);
        n = 0;
        while (!wb_stb && n < 100) begin tick(1); n++; end
        check("to_stb_seen", {31'b0, wb_stb}, 32'd1);
        tick(15);
        check("to_pre_flag", {31'b0, timeout}, 32'd0);
        check("to_pre_stb", {31'b0, wb_stb}, 32'd1);
        tick(1);
`ifdef SDRC_WB_TG_TIMEOUT_EN
        check("to_flag", {31'b0, timeout}, 32'd1);
        check("to_done", {31'b0, done}, 32'd1);
        check("to_busy", {31'b0, busy}, 32'd0);
        check("to_stb", {31'b0, wb_stb}, 32'd0);
        check("to_cyc", {31'b0, wb_cyc}, 32'd0);
`else
        check("nto_flag", {31'b0, timeout}, 32'd0);
        check("nto_busy", {31'b0, busy}, 32'd1);
        check("nto_stb", {31'b0, wb_stb}, 32'd1);
        tick(40);
        check("nto_still_wait", {31'b0, wb_stb}, 32'd1);
`endif
        noack = 1'b0;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sdrc_wb_traffic_gen.md
Name: sdrc_wb_traffic_gen

Overview:
- Parametrised Wishbone bus master that drives the SDRAM controller's WB slave port with incrementing-burst writes of a deterministic pattern, then reads the same region back and checks it.
- Replaces ad-hoc single-beat stimulus with configurable data width, burst length, burst count and run mode.
- Reports error count, first failing address and completion status.
- Sits between the test harness and the controller's WB port; waits for the controller's init-done before issuing traffic.

Parameters:
- WB_DW, 32, WB data width in bits; legal values 8, 16, 32.
- WB_AW, 26, WB byte-address width.
- BURST_LEN, 8, beats per burst; legal range 1..256.
- NUM_BURSTS, 16, bursts per phase; legal range 1..65535.
- TIMEOUT, 1024, ack watchdog limit in cycles; used only with the optional feature.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_resetn  in  1  asynchronous active-low reset.
- sdr_init_done  in  1  controller init complete.
- start  in  1  one-cycle run request.
- mode  in  2  run mode: 0 = write then read-check; 1 = write only; 2 = read-check only; 3 = reserved, treated as 0.
- base_addr  in  WB_AW  start byte address; must be word-aligned.
- seed  in  WB_DW  pattern seed.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next accepted start.
- err_cnt  out  16  read mismatches; saturates at 16'hFFFF.
- first_err_addr  out  WB_AW  byte address of the first mismatch.
- timeout  out  1  watchdog abort flag (optional feature).
- wb_cyc_o  out  1  WB cycle.
- wb_stb_o  out  1  WB strobe.
- wb_we_o  out  1  WB write enable.
- wb_addr_o  out  WB_AW  WB byte address.
- wb_dat_o  out  WB_DW  WB write data.
- wb_sel_o  out  WB_DW/8  WB byte selects; always all ones when stb is high.
- wb_cti_o  out  3  WB cycle type identifier.
- wb_dat_i  in  WB_DW  WB read data.
- wb_ack_i  in  1  WB acknowledge.

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE. A reset mid-run aborts immediately; no WB signal stays asserted.
- FSM states: IDLE, WAIT_INIT, WR_BURST, WR_GAP, RD_BURST, RD_GAP, FINISH.
- IDLE:
  - start=1 latches mode, base_addr and seed; clears err_cnt, first_err_addr, done and timeout; sets busy; goes to WAIT_INIT.
  - start while busy=1 is ignored.
- WAIT_INIT:
  - Stays until sdr_init_done=1.
  - Then goes to WR_BURST for modes 0/1, RD_BURST for mode 2.
- Burst states:
  - cyc=stb=1 throughout the burst.
  - cti=3'b010 on every beat except the last, which uses 3'b111.
  - stb/addr/dat are held stable until ack; on ack, addr += WB_DW/8 and the beat counter advances.
  - After the last beat's ack, cyc/stb drop for exactly one cycle in the matching GAP state.
- Address and pattern:
  - Global beat index g = burst*BURST_LEN + beat.
  - Address = base_addr + g*(WB_DW/8), modulo 2^WB_AW; wrap is silent.
  - Write data = seed + g, modulo 2^WB_DW.
- Read check:
  - On each ack in RD_BURST, wb_dat_i is compared with seed + g.
  - A mismatch increments err_cnt, saturating at 16'hFFFF.
  - If err_cnt was 0, the beat's address is captured in first_err_addr.
- Transitions after the final burst of a phase:
  - Write phase: mode 0 -> RD_BURST with g reset to 0; mode 1 -> FINISH.
  - Read phase -> FINISH.
- FINISH: busy=0, done=1 held; returns to IDLE in the same cycle.
- Latency: first stb occurs one cycle after sdr_init_done is seen high in WAIT_INIT.
- Ack outside stb is ignored.

Optional Feature:
- Macro: SDRC_WB_TG_TIMEOUT_EN.
- Defined:
  - A counter clears on every ack and counts cycles with stb=1 and ack=0.
  - Reaching TIMEOUT drops cyc/stb, sets timeout=1 and done=1, clears busy and returns to IDLE.
- Undefined: no counter exists, timeout is tied to 0, and the block waits for ack indefinitely.

Test Plan:
- Mode 0, WB_DW=32, BURST_LEN=8, NUM_BURSTS=4, base_addr=0x100, seed=0xA5A50000, ideal memory model -> 32 writes at 0x100..0x17C with data 0xA5A50000..0xA5A5001F, then 32 reads; err_cnt=0, done=1; cti=3'b111 on beats 7, 15, 23, 31.
- Mode 2 with the memory model corrupting the word at 0x108 -> err_cnt=1, first_err_addr=0x108.
- start asserted before sdr_init_done; init_done rises 50 cycles later -> no stb before it; first stb one cycle after; a second start while busy has no effect.
- Slave inserts 3 wait states per beat -> addr/dat/stb held stable throughout; transfer count unchanged; single-cycle cyc gap between bursts.
- wb_resetn dropped mid-write burst -> cyc/stb/busy go 0 immediately; after release, a fresh start runs cleanly with err_cnt=0.
- With SDRC_WB_TG_TIMEOUT_EN defined, TIMEOUT=16, slave never acks -> timeout=1, done=1, busy=0 exactly 16 cycles after stb rises.
